// File: rtl/e_ecc_pkg.sv
// Shared ECC field-arithmetic definitions: datapath widths, modular
// subtractor state encoding and curve moduli.
package e_ecc_pkg;

    localparam int unsigned ECC_WIDTH = 256;
    localparam int unsigned ECC_LIMB  = 64;
    localparam int unsigned ECC_NLIMB = ECC_WIDTH / ECC_LIMB;

    // e_mod_sub control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2
    } e_mod_sub_state_e;

    // NIST P-256 field prime
    localparam logic [ECC_WIDTH-1:0] P256_P =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

endpackage

// File: rtl/e_limb_addsub.sv
// Single-limb combinational adder/subtractor with carry/borrow in and out.
// sub_i=0: {cout, res} = x + y + cin
// sub_i=1: {bout, res} = x - y - bin (bout=1 on underflow)
module e_limb_addsub #(
    parameter int unsigned LIMB = 64
) (
    input  logic            sub_i,
    input  logic [LIMB-1:0] x_i,
    input  logic [LIMB-1:0] y_i,
    input  logic            cin_i,
    output logic [LIMB-1:0] res_c_o,
    output logic            cout_c_o
);

    logic [LIMB:0] ext;

    // One extra bit captures the carry, or the borrow as a wrapped sign bit
    always_comb begin
        if (sub_i) begin
            ext = {1'b0, x_i} - {1'b0, y_i} - (LIMB+1)'(cin_i);
        end else begin
            ext = {1'b0, x_i} + {1'b0, y_i} + (LIMB+1)'(cin_i);
        end
    end

    assign res_c_o  = ext[LIMB-1:0];
    assign cout_c_o = ext[LIMB];

endmodule

// File: rtl/e_mod_sub.sv
// Limb-serial modular subtractor: s = (a - b) mod p.
// A SUB pass walks the limbs computing a - b; if the final borrow is set a
// FIX pass adds p back limb by limb. One shared limb adder serves both.
// Build option E_MOD_SUB_CT_EN: constant-time mode, FIX always runs and
// adds either p or 0 depending on the SUB borrow (fixed 2*NLIMB latency).
module e_mod_sub
    import e_ecc_pkg::*;
#(
    parameter int unsigned WIDTH = ECC_WIDTH,
    parameter int unsigned LIMB  = ECC_LIMB
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] p_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             borrow_o,
    output logic [WIDTH-1:0] s_o
);

    localparam int unsigned NLIMB = WIDTH / LIMB;
    localparam int unsigned CNT_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NLIMB - 1);

    e_mod_sub_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] w_q, w_d;
    logic             bw_q, bw_d;
    logic             fin_bw_q, fin_bw_d;
    logic             busy_d, done_d, borrow_d;
    logic [WIDTH-1:0] s_d;

    logic [LIMB-1:0]  a_l, b_l, p_l, w_l;
    logic [LIMB-1:0]  add_x, add_y, add_res;
    logic             add_sub, add_cout;
    logic             last;

    // Select the active limb of each operand and steer the shared adder
    always_comb begin
        a_l = '0;
        b_l = '0;
        p_l = '0;
        w_l = '0;
        for (int unsigned i = 0; i < NLIMB; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_l = a_q[i*LIMB +: LIMB];
                b_l = b_q[i*LIMB +: LIMB];
                p_l = p_q[i*LIMB +: LIMB];
                w_l = w_q[i*LIMB +: LIMB];
            end
        end
        add_sub = (state_q == SUB);
        add_x   = add_sub ? a_l : w_l;
        // fin_bw_q is always 1 in FIX unless constant-time mode forced FIX
        add_y   = add_sub ? b_l : (fin_bw_q ? p_l : '0);
    end

    e_limb_addsub #(
        .LIMB (LIMB)
    ) u_limb_addsub (
        .sub_i    (add_sub),
        .x_i      (add_x),
        .y_i      (add_y),
        .cin_i    (bw_q),
        .res_c_o  (add_res),
        .cout_c_o (add_cout)
    );

    assign last = (cnt_q == CNT_LAST);

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        w_d      = w_q;
        bw_d     = bw_q;
        fin_bw_d = fin_bw_q;
        busy_d   = busy_o;
        done_d   = 1'b0;
        borrow_d = borrow_o;
        s_d      = s_o;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d      = a_i;
                    b_d      = b_i;
                    p_d      = p_i;
                    cnt_d    = '0;
                    bw_d     = 1'b0;
                    fin_bw_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = SUB;
                end
            end

            SUB: begin
                for (int unsigned i = 0; i < NLIMB; i++) begin
                    if (cnt_q == CNT_W'(i)) w_d[i*LIMB +: LIMB] = add_res;
                end
                bw_d  = add_cout;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    fin_bw_d = add_cout;
                    cnt_d    = '0;
`ifdef E_MOD_SUB_CT_EN
                    bw_d    = 1'b0;
                    state_d = FIX;
`else
                    if (add_cout) begin
                        bw_d    = 1'b0;
                        state_d = FIX;
                    end else begin
                        s_d      = w_d;
                        borrow_d = 1'b0;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = IDLE;
                    end
`endif
                end
            end

            FIX: begin
                for (int unsigned i = 0; i < NLIMB; i++) begin
                    if (cnt_q == CNT_W'(i)) w_d[i*LIMB +: LIMB] = add_res;
                end
                bw_d  = add_cout;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    // Final carry-out of the add-back is dropped (mod 2^WIDTH)
                    bw_d     = 1'b0;
                    cnt_d    = '0;
                    s_d      = w_d;
                    borrow_d = fin_bw_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            w_q      <= '0;
            bw_q     <= 1'b0;
            fin_bw_q <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            borrow_o <= 1'b0;
            s_o      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p_q      <= p_d;
            w_q      <= w_d;
            bw_q     <= bw_d;
            fin_bw_q <= fin_bw_d;
            busy_o   <= busy_d;
            done_o   <= done_d;
            borrow_o <= borrow_d;
            s_o      <= s_d;
        end
    end

endmodule

// File: tb/tb_e_mod_sub.sv
// Scoreboard bench for e_mod_sub: the driver pushes expected results with
// their due cycle, the monitor pops and compares on every done_o.
module tb_e_mod_sub;
    import e_ecc_pkg::*;

    localparam logic [255:0] P   = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
    localparam logic [255:0] PM7 = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFF8;
    localparam logic [255:0] PM1 = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFE;

    typedef struct {
        logic [255:0] s;
        logic         borrow;
        int           due;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic         start_i;
    logic [255:0] a_i, b_i, p_i;
    logic         busy_o, done_o, borrow_o;
    logic [255:0] s_o;

    int   n_checks;
    int   n_pass;
    int   cyc;
    logic prev_done;
    exp_t exp_q[$];

    e_mod_sub dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_i  (start_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .p_i      (p_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .borrow_o (borrow_o),
        .s_o      (s_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    function automatic int lat(input logic borrow);
`ifdef E_MOD_SUB_CT_EN
        return 8;
`else
        return borrow ? 8 : 4;
`endif
    endfunction

    // Monitor: every done_o must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (prev_done) check("done_single_pulse", 256'(done_o), 256'(0));
        if (reset_n && done_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 256'(1), 256'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("s_o", s_o, e.s);
                check("borrow_o", 256'(borrow_o), 256'(e.borrow));
                check("latency_cycle", 256'(cyc), 256'(e.due));
            end
        end
        prev_done = done_o;
    end

    // Issue one request; when push=1 register its expected result
    task automatic start_op(input logic [255:0] a, input logic [255:0] b,
                            input logic [255:0] es, input logic eb, input bit push);
        @(negedge clk);
        a_i = a; b_i = b; p_i = P; start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        a_i = '0; b_i = '0; p_i = '0;
        if (push) begin
            exp_t e;
            e.s = es; e.borrow = eb; e.due = cyc + lat(eb);
            exp_q.push_back(e);
        end
    endtask

    // Bounded wait for all outstanding results and an idle DUT
    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_timeout", 256'(exp_q.size()), 256'(0));
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; prev_done = 1'b0;
        reset_n = 1'b0; start_i = 1'b0;
        a_i = '0; b_i = '0; p_i = '0;
        #12;
        check("rst_busy", 256'(busy_o), 256'(0));
        check("rst_done", 256'(done_o), 256'(0));
        check("rst_borrow", 256'(borrow_o), 256'(0));
        check("rst_s", s_o, 256'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // Basic no-borrow and borrow cases
        start_op(256'd10, 256'd3, 256'd7, 1'b0, 1'b1);
        check("busy_after_accept", 256'(busy_o), 256'(1));
        wait_idle();
        start_op(256'd3, 256'd10, PM7, 1'b1, 1'b1);
        wait_idle();

        // Borrow rippling across a limb boundary
        start_op(256'h1_0000000000000000, 256'd1, 256'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1);
        wait_idle();

        // Extremes: 0 - p wraps to 0 after add-back; all-ones minus 0
        start_op(256'd0, P, 256'd0, 1'b1, 1'b1);
        wait_idle();
        start_op({256{1'b1}}, 256'd0, {256{1'b1}}, 1'b0, 1'b1);
        wait_idle();

        // Back-to-back: start held in the done_o cycle is accepted at once
        start_op(PM1, PM1, 256'd0, 1'b0, 1'b1);
        begin
            int n;
            n = 0;
            while (!done_o && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("b2b_done_seen", 256'(done_o), 256'(1));
            check("b2b_busy_in_done", 256'(busy_o), 256'(0));
            a_i = 256'd5; b_i = 256'd6; p_i = P; start_i = 1'b1;
            @(posedge clk);
            #1;
            start_i = 1'b0;
            begin
                exp_t e;
                e.s = PM1; e.borrow = 1'b1; e.due = cyc + lat(1'b1);
                exp_q.push_back(e);
            end
            check("b2b_busy", 256'(busy_o), 256'(1));
        end
        wait_idle();

        // Start while busy is ignored
        start_op(256'd100, 256'd1, 256'd99, 1'b0, 1'b1);
        @(negedge clk);
        a_i = 256'd7; b_i = 256'd1; p_i = P; start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check("ignored_busy", 256'(busy_o), 256'(1));
        wait_idle();
        repeat (10) @(negedge clk);

        // Reset during SUB abandons the operation
        start_op(256'd3, 256'd10, 256'd0, 1'b1, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 256'(busy_o), 256'(0));
        check("midrst_done", 256'(done_o), 256'(0));
        check("midrst_borrow", 256'(borrow_o), 256'(0));
        check("midrst_s", s_o, 256'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        check("midrst_still_idle", 256'(busy_o), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
